// File: rtl/matrix_gen_3x3_pkg.sv
// Shared image-processing defaults and helpers for the 3x3 window generator
// and the downstream median filter.
package matrix_gen_3x3_pkg;

    localparam int unsigned IMG_HDISP_DEF = 640;
    localparam int unsigned IMG_VDISP_DEF = 480;
    localparam int unsigned DATA_W_DEF    = 8;

    // Counter/address width for a range of n values; never narrower than 1 bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef struct packed {
        logic vsync;
        logic href;
        logic clken;
    } sync_t;

endpackage

// File: rtl/matrix_gen_3x3_line_buf_sdp.sv
// Simple dual-port line buffer: one write port, one read port with a
// registered (1-cycle) read that returns the old data on a same-address write.
module line_buf_sdp
    import matrix_gen_3x3_pkg::*;
#(
    parameter int unsigned DEPTH  = IMG_HDISP_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    localparam int unsigned ADDR_W = cnt_w(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        if (re)
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/matrix_gen_3x3.sv
// 3x3 sliding-window generator over a raster pixel stream, built from two
// line buffers; border positions above row 0 / left of col 0 read as zero.
module matrix_gen_3x3
    import matrix_gen_3x3_pkg::*;
#(
    parameter int unsigned IMG_HDISP = IMG_HDISP_DEF,
    parameter int unsigned IMG_VDISP = IMG_VDISP_DEF,
    parameter int unsigned DATA_W    = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              per_frame_vsync,
    input  logic              per_frame_href,
    input  logic              per_frame_clken,
    input  logic [DATA_W-1:0] per_img_data,
    output logic              matrix_frame_vsync,
    output logic              matrix_frame_href,
    output logic              matrix_frame_clken,
    output logic [DATA_W-1:0] data11,
    output logic [DATA_W-1:0] data12,
    output logic [DATA_W-1:0] data13,
    output logic [DATA_W-1:0] data21,
    output logic [DATA_W-1:0] data22,
    output logic [DATA_W-1:0] data23,
    output logic [DATA_W-1:0] data31,
    output logic [DATA_W-1:0] data32,
    output logic [DATA_W-1:0] data33
);

    localparam int unsigned COL_W = cnt_w(IMG_HDISP);
    localparam int unsigned ROW_W = cnt_w(IMG_VDISP);

    logic [COL_W-1:0]  col, col1;
    logic [ROW_W-1:0]  row, row1;
    logic [DATA_W-1:0] pix1, b1, b2;
    sync_t             sync0, sync1, sync2;

    assign sync0 = '{vsync: per_frame_vsync, href: per_frame_href, clken: per_frame_clken};

    always_ff @(posedge clk) begin
        if (rst || per_frame_vsync) begin
            col <= '0;
            row <= '0;
        end else if (per_frame_clken) begin
            if (col == COL_W'(IMG_HDISP - 1)) begin
                col <= '0;
                row <= (row == ROW_W'(IMG_VDISP - 1)) ? '0 : row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

    line_buf_sdp #(
        .DEPTH  (IMG_HDISP),
        .DATA_W (DATA_W)
    ) u_buf1 (
        .clk   (clk),
        .we    (per_frame_clken),
        .waddr (col),
        .wdata (per_img_data),
        .re    (per_frame_clken),
        .raddr (col),
        .rdata (b1)
    );

    // The old buf1 entry only appears on the registered read port, so buf2 is
    // written one cycle later at the stage-1 column. That column is not read
    // again until the next line, so the read-before-write ordering holds.
    line_buf_sdp #(
        .DEPTH  (IMG_HDISP),
        .DATA_W (DATA_W)
    ) u_buf2 (
        .clk   (clk),
        .we    (sync1.clken),
        .waddr (col1),
        .wdata (b1),
        .re    (per_frame_clken),
        .raddr (col),
        .rdata (b2)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            col1  <= '0;
            row1  <= '0;
            pix1  <= '0;
        end else begin
            sync1 <= sync0;
            if (per_frame_clken) begin
                col1 <= col;
                row1 <= row;
                pix1 <= per_img_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync2  <= '0;
            data11 <= '0; data12 <= '0; data13 <= '0;
            data21 <= '0; data22 <= '0; data23 <= '0;
            data31 <= '0; data32 <= '0; data33 <= '0;
        end else begin
            sync2 <= sync1;
            if (sync1.clken) begin
                // Row masking on the incoming column, column masking on the shift.
                data13 <= (row1 > ROW_W'(1)) ? b2 : '0;
                data23 <= (row1 != '0)       ? b1 : '0;
                data33 <= pix1;
                data12 <= (col1 != '0)       ? data13 : '0;
                data22 <= (col1 != '0)       ? data23 : '0;
                data32 <= (col1 != '0)       ? data33 : '0;
                data11 <= (col1 > COL_W'(1)) ? data12 : '0;
                data21 <= (col1 > COL_W'(1)) ? data22 : '0;
                data31 <= (col1 > COL_W'(1)) ? data32 : '0;
            end
        end
    end

    assign matrix_frame_vsync = sync2.vsync;
    assign matrix_frame_href  = sync2.href;
    assign matrix_frame_clken = sync2.clken;

endmodule

// File: tb/tb_matrix_gen_3x3.sv
// Directed bench for matrix_gen_3x3 on a 4x4 image: every cycle checks the
// 2-cycle-delayed syncs and the window (or its hold) against an image model.
module tb_matrix_gen_3x3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       per_frame_vsync = 1'b0;
    logic       per_frame_href  = 1'b0;
    logic       per_frame_clken = 1'b0;
    logic [7:0] per_img_data    = '0;
    logic       matrix_frame_vsync, matrix_frame_href, matrix_frame_clken;
    logic [7:0] data11, data12, data13, data21, data22, data23, data31, data32, data33;

    matrix_gen_3x3 #(
        .IMG_HDISP (4),
        .IMG_VDISP (4),
        .DATA_W    (8)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .per_frame_vsync    (per_frame_vsync),
        .per_frame_href     (per_frame_href),
        .per_frame_clken    (per_frame_clken),
        .per_img_data       (per_img_data),
        .matrix_frame_vsync (matrix_frame_vsync),
        .matrix_frame_href  (matrix_frame_href),
        .matrix_frame_clken (matrix_frame_clken),
        .data11 (data11), .data12 (data12), .data13 (data13),
        .data21 (data21), .data22 (data22), .data23 (data23),
        .data31 (data31), .data32 (data32), .data33 (data33)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit   v;
        int   r;
        int   c;
        logic vs;
        logic hr;
    } tag_t;

    int   n_asrt = 0;
    int   n_fail = 0;
    int   img [4][4];
    int   last [9];
    bit   median_on = 0;
    tag_t cur, p1, p2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_win(input int r, input int c, input int k);
        int rr, cc;
        rr = r - 2 + k / 3;
        cc = c - 2 + k % 3;
        return (rr < 0 || cc < 0) ? 0 : img[rr][cc];
    endfunction

    function automatic logic [7:0] median9(input logic [7:0] a [9]);
        logic [7:0] s [9];
        logic [7:0] t;
        s = a;
        for (int i = 0; i < 9; i++)
            for (int j = 0; j < 8 - i; j++)
                if (s[j] > s[j+1]) begin
                    t = s[j]; s[j] = s[j+1]; s[j+1] = t;
                end
        return s[4];
    endfunction

    task automatic drive(input logic vs, input logic hr, input logic ce,
                         input int pix, input int r, input int c);
        per_frame_vsync = vs;
        per_frame_href  = hr;
        per_frame_clken = ce;
        per_img_data    = pix[7:0];
        cur = '{v: ce, r: r, c: c, vs: vs, hr: hr};
    endtask

    task automatic tick();
        logic [7:0] w [9];
        int e;
        @(posedge clk);
        if (rst) begin
            p1 = '{v: 0, r: 0, c: 0, vs: 1'b0, hr: 1'b0};
            p2 = p1;
            for (int k = 0; k < 9; k++) last[k] = 0;
        end else begin
            p2 = p1;
            p1 = cur;
        end
        #1;
        chk("clken", matrix_frame_clken, p2.v);
        chk("vsync", matrix_frame_vsync, p2.vs);
        chk("href",  matrix_frame_href,  p2.hr);
        w = '{data11, data12, data13, data21, data22, data23, data31, data32, data33};
        for (int k = 0; k < 9; k++) begin
            e = p2.v ? exp_win(p2.r, p2.c, k) : last[k];
            chk($sformatf("data%0d%0d r%0d c%0d", k / 3 + 1, k % 3 + 1, p2.r, p2.c), w[k], e);
            last[k] = e;
        end
        if (median_on && p2.v && p2.r >= 2 && p2.c >= 2)
            chk($sformatf("median r%0d c%0d", p2.r, p2.c), median9(w), 8'h80);
    endtask

    // Stops with a reset pulse alongside pixel (stop_r, stop_c) when given.
    task automatic run_frame(input int gap, input bit vs_first, input int stop_r, input int stop_c);
        if (vs_first) begin
            drive(1, 0, 0, 0, 0, 0); tick(); tick();
            drive(0, 0, 0, 0, 0, 0); tick();
        end
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (r == stop_r && c == stop_c) begin
                    rst = 1'b1;
                    drive(0, 1, 1, img[r][c], r, c);
                    tick();
                    rst = 1'b0;
                    drive(0, 0, 0, 0, 0, 0);
                    return;
                end
                drive(0, 1, 1, img[r][c], r, c);
                tick();
                for (int g = 0; g < gap; g++) begin
                    drive(0, 1, 0, 0, r, c);
                    tick();
                end
            end
            drive(0, 0, 0, 0, 0, 0);
            tick(); tick();
        end
        tick(); tick();
    endtask

    task automatic set_img(input int base, input int rs, input int special);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                img[r][c] = base + rs * r + c;
        if (special >= 0) img[0][0] = special;
    endtask

    initial begin
        cur = '{v: 0, r: 0, c: 0, vs: 1'b0, hr: 1'b0};
        p1 = cur;
        p2 = cur;
        for (int k = 0; k < 9; k++) last[k] = 0;

        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        tick(); tick(); tick();
        chk("reset data33", data33, 8'h00);
        chk("reset data11", data11, 8'h00);
        rst = 1'b0;

        // first pixel right after reset, no vsync: 0x55 alone in the window
        set_img(0, 16, 8'h55);
        run_frame(0, 0, -1, -1);

        // 16*row+col pattern, gap-free then 1-in-3 clken
        set_img(0, 16, -1);
        run_frame(0, 1, -1, -1);
        run_frame(2, 1, -1, -1);

        // reset at row 2 col 1, then restart straight away
        run_frame(0, 1, 2, 1);
        chk("midrst clken", matrix_frame_clken, 1'b0);
        chk("midrst data22", data22, 8'h00);
        set_img(0, 16, 8'h55);
        run_frame(0, 0, -1, -1);

        // back-to-back frames with different content
        set_img(8'hC0, 4, -1);
        run_frame(0, 1, -1, -1);
        set_img(0, 16, -1);
        run_frame(0, 1, -1, -1);

        // constant 0x80 with one 0xFF outlier through a median of the window
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                img[r][c] = 8'h80;
        img[2][2] = 8'hFF;
        median_on = 1;
        run_frame(0, 1, -1, -1);
        median_on = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule

// File: doc/matrix_gen_3x3.md
MATRIX_GEN_3X3 -- requirements
Module: matrix_gen_3x3

Interface
REQ-001 SHALL have parameter IMG_HDISP, default 640, active pixels per line (line-buffer depth).
REQ-002 SHALL have parameter IMG_VDISP, default 480, active lines per frame.
REQ-003 SHALL have parameter DATA_W, default 8, pixel width in bits.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-006 SHALL have port per_frame_vsync, input, 1, frame sync; high between frames.
REQ-007 SHALL have port per_frame_href, input, 1, line-active qualifier.
REQ-008 SHALL have port per_frame_clken, input, 1, pixel-valid strobe, only high while href high.
REQ-009 SHALL have port per_img_data, input, DATA_W, incoming pixel in raster order.
REQ-010 SHALL have port matrix_frame_vsync, output, 1, per_frame_vsync delayed 2 cycles.
REQ-011 SHALL have port matrix_frame_href, output, 1, per_frame_href delayed 2 cycles.
REQ-012 SHALL have port matrix_frame_clken, output, 1, per_frame_clken delayed 2 cycles; qualifies the window.
REQ-013 SHALL have ports data11..data33, output, DATA_W each, 3x3 window, row-major; data33 = newest pixel.

Function
REQ-014 SHALL keep col counter (0..IMG_HDISP-1) and row counter (0..IMG_VDISP-1) addressing the current input pixel.
REQ-015 SHALL advance col by 1 on each clken; at IMG_HDISP-1 col wraps to 0 and row increments.
REQ-016 SHALL wrap row from IMG_VDISP-1 to 0, and force col=row=0 whenever per_frame_vsync is high.
REQ-017 SHALL hold two line buffers of IMG_HDISP entries: buf1 = row r-1, buf2 = row r-2, both indexed by col.
REQ-018 SHALL, on clken, read buf1[col] and buf2[col] and in the same cycle write buf1[col]<=pixel, buf2[col]<=old buf1[col] (read-before-write).
REQ-019 SHALL register the read column (stage 1) then shift it into the window (stage 2): data_x3 <= new column, data_x2 <= data_x3, data_x1 <= data_x2.
REQ-020 SHALL place pixel (r,c) at data33, (r-1,c) at data23, (r-2,c) at data13 on the cycle matrix_frame_clken is high for it.
REQ-021 SHALL output 0 for any window position with row<0 (rows 0,1) or col<0 (cols 0,1); masking uses the stage-aligned row/col.
REQ-022 SHALL hold all window outputs when stage-2 clken is low; no shift on idle cycles.
REQ-023 SHALL produce exactly one valid window per input clken, latency exactly 2 cycles, no backpressure.
REQ-024 SHALL not depend on line-buffer initial contents (masking of REQ-021 hides stale data).

Reset
REQ-025 SHALL on rst drive matrix_frame_vsync/href/clken to 0, data11..data33 to 0, col and row to 0.
REQ-026 SHALL not clear line-buffer RAM on rst; rst mid-frame SHALL restart at row 0 col 0 with masked output.
REQ-027 SHALL accept first pixel on the cycle after rst deasserts.

Structure
REQ-028 SHALL take IMG_HDISP, IMG_VDISP, DATA_W defaults from the shared image-processing package, shared with the downstream median filter.
REQ-029 SHALL instantiate one sub-module, line_buf_sdp, a simple dual-port RAM (DATA_W x IMG_HDISP, 1-cycle registered read), twice.
REQ-030 SHALL compute col/row counter widths with $clog2 of the parameters in the package.

Verification
REQ-031 SHALL test IMG_HDISP=4, IMG_VDISP=4, pixel = 16*row+col: at row2 col2, data11..data33 = 00,01,02,10,11,12,20,21,22.
REQ-032 SHALL test row0 col0 pixel 0x55 -> 2 cycles later clken=1, data33=0x55, other eight outputs 0.
REQ-033 SHALL test clken gaps (1 of every 3 cycles) over same frame -> windows identical to gap-free run, latency still 2.
REQ-034 SHALL test rst during row2 col1, then restart frame -> first window masked as REQ-032, counters at 0.
REQ-035 SHALL test two back-to-back frames with vsync between -> frame-2 row0/row1 windows show zeros above, not frame-1 data.
REQ-036 SHALL test end-to-end with median filter: 4x4 frame of constant 0x80 with single 0xFF at (2,2) -> median 0x80 at every window.
